// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DEF_WIDTH  : default operand / quotient / remainder width
//   state_t    : FSM encoding (IDLE, CALC, DONE)
//   cnt_width  : bit counter width for a given operand width
package divider_seq_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index WIDTH iterations; never let it collapse to zero bits.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in   in  WIDTH  partial remainder before this step
//   bit_in   in  1      next dividend bit (MSB of the shifting dividend)
//   divisor  in  WIDTH  divisor
//   rem_out  out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step
module divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The shifted remainder can momentarily need WIDTH+1 bits, so the
  // compare is done one bit wider than the operands. When the subtract
  // is taken the true difference is below the divisor, so the low WIDTH
  // bits of the modular difference are exact.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    diff    = shifted[WIDTH-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned divider: y = a / b, remainder = a % b.
// Restoring shift-subtract, one quotient bit per clock; fixed latency of
// WIDTH+1 edges from the accepted start edge to done.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous reset, active low
//   start      in  1      launch a divide (honoured in IDLE or DONE)
//   a          in  WIDTH  dividend, captured on accepted start
//   b          in  WIDTH  divisor, captured on accepted start
//   done       out 1      result valid (registered)
//   y          out WIDTH  quotient (registered)
//   remainder  out WIDTH  remainder (registered)
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             drain;
  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign accept = start && ((state == IDLE) || (state == DONE));

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // CALC exits only after the extra result-load cycle (drain) so that
  // done appears WIDTH+1 edges after the start edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (drain) next_state = DONE;
      DONE:    if (start) next_state = CALC;
      default: next_state = IDLE;
    endcase
  end

  // WIDTH iterations run with the counter going WIDTH-1 down to 0; the
  // drain cycle that follows copies the working registers to the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      drain     <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
      remainder <= '0;
    end else if (accept) begin
      dvd   <= a;
      dvs   <= b;
      rem   <= '0;
      quo   <= '0;
      cnt   <= CW'(WIDTH - 1);
      drain <= 1'b0;
      done  <= 1'b0;
    end else if (state == CALC) begin
      if (drain) begin
        y         <= quo;
        remainder <= rem;
        done      <= 1'b1;
        drain     <= 1'b0;
      end else begin
        rem <= step_rem;
        quo <= (quo << 1) | WIDTH'(step_q);
        dvd <= dvd << 1;
        if (cnt == '0) drain <= 1'b1;
        else           cnt   <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: expected results are queued when a
// divide is launched and compared when done rises.
module tb_divider_seq;

  localparam int W       = 16;
  localparam int LATENCY = W + 1;
  localparam int TIMEOUT = 60;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         done;
  logic [W-1:0] y;
  logic [W-1:0] remainder;

  exp_t         sb[$];
  int           checks;
  int           errors;
  logic [W-1:0] lastY;
  logic [W-1:0] lastR;

  divider_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .done      (done),
    .y         (y),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] da, input logic [W-1:0] db);
    exp_t e;
    if (db == '0) begin
      e.q = '1;
      e.r = da;
    end else begin
      e.q = da / db;
      e.r = da % db;
    end
    return e;
  endfunction

  // Launch one divide, wait for done with a bound, then score it.
  // noisy=1 pulses start with junk operands twice during CALC.
  task automatic applyStimulus(input logic [W-1:0] da, input logic [W-1:0] db, input bit noisy);
    int   edges;
    exp_t e;
    @(negedge clk);
    a     = da;
    b     = db;
    start = 1'b1;
    sb.push_back(model(da, db));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    checkOutput("done_low_after_start", 32'(done), 32'd0);
    edges = 0;
    while (edges < TIMEOUT) begin
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
      if (done) break;
      if (edges == 5) begin
        checkOutput("hold_y", 32'(y), 32'(lastY));
        checkOutput("hold_rem", 32'(remainder), 32'(lastR));
      end
      if (noisy && (edges == 3 || edges == 8)) begin
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd2;
      end
    end
    checkOutput("latency", 32'(edges), 32'(LATENCY));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("quotient", 32'(y), 32'(e.q));
      checkOutput("remainder", 32'(remainder), 32'(e.r));
      lastY = e.q;
      lastR = e.r;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lastY  = '0;
    lastR  = '0;
    rst    = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_y", 32'(y), 32'd0);
    checkOutput("reset_rem", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(16'd100, 16'd3, 1'b0);
    applyStimulus(16'd255, 16'd5, 1'b0);
    applyStimulus(16'd1234, 16'd56, 1'b0);
    applyStimulus(16'd5, 16'd7, 1'b0);
    applyStimulus(16'd65535, 16'd1, 1'b0);
    applyStimulus(16'd40000, 16'd123, 1'b1);
    applyStimulus(16'd1000, 16'd0, 1'b0);

    // Abort a divide mid-flight; outputs must clear without a clock edge.
    @(negedge clk);
    a     = 16'd100;
    b     = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_y", 32'(y), 32'd0);
    checkOutput("abort_rem", 32'(remainder), 32'd0);
    lastY = '0;
    lastR = '0;
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(16'd100, 16'd3, 1'b0);
    applyStimulus(16'($urandom()), 16'($urandom_range(1, 300)), 1'b0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
